seg_scan_scheduler: RTL and testbench
=====================================

Name: seg_scan_scheduler

Overview:
- Time-multiplexes one 4-digit common-anode 7-segment display from a single system clock.
- Contains its own prescaler and digit-slot sequencer, a blank-before-drive anti-ghosting FSM and a hex-to-segment decoder.
- Double-buffers the display value behind a valid/ready load handshake, so a new value only appears at a frame boundary and never tears mid-scan.
- Sits between the application logic that produces a 16-bit value and the board's anode/cathode pins.

Parameters:
- PRESCALE, 100000: clocks per digit slot. Legal range >= 2. At 100 MHz this gives a 1 kHz slot rate and a 250 Hz frame rate.
- BLANK_CYCLES, 1000: clocks at the start of each slot with all anodes off. Legal range 1 <= BLANK_CYCLES < PRESCALE.

Ports:
- clock, input, 1: system clock; all state changes on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- load, input, 1: valid strobe for value_in/dp_in/blank_in.
- value_in, input, 16: four hex nibbles; [3:0] is the rightmost digit (digit 0).
- dp_in, input, 4: decimal point enable per digit, 1 = lit.
- blank_in, input, 4: per-digit blank, 1 = digit dark.
- ready, output, 1: high when a load will be accepted.
- digit_sel, output, 2: current digit slot, 0..3.
- anode, output, 4: active-low digit enables; anode[i] drives digit i.
- cathode, output, 7: active-low segments {g,f,e,d,c,b,a}.
- dp, output, 1: active-low decimal point.

Behaviour:
- Reset (async, any time, including mid-slot or mid-handshake):
  - Counters: cnt=0, digit_sel=0.
  - FSM = BLANK.
  - Outputs: anode=4'b1111, cathode=7'b1111111, dp=1, ready=1.
  - Active registers: value 16'h0000, dp 0, blank 0.
  - Pending buffer: cleared, invalid.
- Prescaler:
  - cnt runs 0..PRESCALE-1 and wraps to 0.
  - The wrap edge is the slot end.
  - digit_sel increments modulo 4 on every slot end (3 -> 0 wraps).
- FSM:
  - BLANK: anode=4'b1111. When cnt==BLANK_CYCLES-1, go to DRIVE.
  - DRIVE: anode[digit_sel]=0, all other anode bits 1. At slot end, go to BLANK.
  - Total drive time per slot = PRESCALE-BLANK_CYCLES clocks.
- Output registers:
  - anode, cathode and dp are registered and update on the same edge as the FSM/digit_sel transition.
  - They never glitch between two digits; there is always at least one all-off cycle between digits.
- Segment decoding:
  - Decoded from the active nibble value[4*digit_sel+3 : 4*digit_sel], standard hex glyphs.
  - Examples: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
  - dp = ~active_dp[digit_sel].
  - If active_blank[digit_sel]=1: cathode=7'b1111111 and dp=1. The anode still scans, so timing is unchanged.
  - In BLANK, cathode and dp are 1s.
- Load handshake:
  - A load is accepted on an edge where load=1 and ready=1.
  - On acceptance: capture value_in/dp_in/blank_in into the pending buffer; ready=0 from the next cycle.
  - load while ready=0 is ignored; the pending buffer is not overwritten.
- Commit:
  - Frame end = the slot-end edge where digit_sel==3.
  - At frame end with pending valid: copy pending to active, clear pending, set ready=1 on that same edge.
  - Latency from acceptance to first display: up to one frame (4*PRESCALE clocks) plus BLANK_CYCLES.
- Simultaneous events:
  - load=1 with ready=1 on a frame-end edge: the data is staged, not committed; it commits at the next frame end.
  - A commit never takes data accepted on the same edge.
- Scanning never stalls, regardless of handshake activity.

Test Plan (PRESCALE=8, BLANK_CYCLES=2, frame=32 clocks):
1. Reset release, no load -> anode all 1s for cycles 0-1; then anode=1110 and cathode=1000000 for cycles 2-7; slots then cycle 1101, 1011, 0111, each showing "0"; digit_sel 0..3 with period 32.
2. Load 16'h1A8F with dp_in=0100, blank_in=0 at cycle 5 -> ready low from cycle 6; old value displayed until cycle 32; from the frame boundary: digit0=F (0001110), digit1=8 (0000000), digit2=A (0001000) with dp=0, digit3=1 (1111001); ready=1 at cycle 32.
3. Second load at cycle 10 while ready=0 -> ignored; the first value still commits; pending is not corrupted.
4. Load asserted exactly on the frame-end edge with ready=1 -> no change that frame; commits one frame later (+32 clocks).
5. blank_in=4'b1000 with value 16'h1234 -> digit3 slot has anode=0111 with cathode=1111111 and dp=1; digits 0-2 show 4, 3, 2.
6. reset_n pulsed low mid-DRIVE of digit 2 while pending is valid -> outputs go off and ready=1 immediately (async); after release, digit 0 shows "0"; pending is discarded.

Source files
------------

// File: rtl/seg_scan_scheduler_if.sv
// Load handshake and display-pin bundle for seg_scan_scheduler.
// The master side is the application plus the board pins; the slave side is the scheduler.
interface seg_scan_scheduler_if;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        ready;
    logic [1:0]  digit_sel;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        dp;

    modport master (
        output load, value_in, dp_in, blank_in,
        input  ready, digit_sel, anode, cathode, dp
    );

    modport slave (
        input  load, value_in, dp_in, blank_in,
        output ready, digit_sel, anode, cathode, dp
    );
endinterface

// File: rtl/seg_scan_scheduler.sv
// 4-digit common-anode 7-segment scan scheduler.
// A prescaler divides the clock into digit slots. Each slot starts with an
// all-anodes-off blank window before the digit is driven. The displayed value
// is double-buffered behind a valid/ready load, and a new value is swapped in
// only at a frame boundary, so a scan never shows a mix of old and new digits.
module seg_scan_scheduler #(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input logic                 clock,
    input logic                 reset_n,
    seg_scan_scheduler_if.slave bus
);
    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Active-low glyphs {g,f,e,d,c,b,a} for hex digits 0..F.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            4'hF:    hex7 = 7'b0001110;
            default: hex7 = 7'b1111111;
        endcase
    endfunction

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_digit;
    state_t        r_state;
    logic [3:0]    r_anode;
    logic [6:0]    r_cathode;
    logic          r_dp;
    logic          r_ready;
    logic [15:0]   r_act_val;
    logic [3:0]    r_act_dp;
    logic [3:0]    r_act_blank;
    logic [15:0]   r_pend_val;
    logic [3:0]    r_pend_dp;
    logic [3:0]    r_pend_blank;

    logic          w_slot_end;
    logic          w_frame_end;
    logic          w_blank_done;
    logic          w_accept;
    logic          w_commit;
    logic [3:0]    w_nibble;
    logic [3:0]    w_anode_on;
    logic [6:0]    w_seg;
    logic          w_dp;

    assign w_slot_end   = (r_cnt == CW'(PRESCALE - 1));
    assign w_frame_end  = w_slot_end && (r_digit == 2'd3);
    assign w_blank_done = (r_cnt == CW'(BLANK_CYCLES - 1));
    // ready low means the pending buffer holds an uncommitted value.
    assign w_accept     = bus.load && r_ready;
    assign w_commit     = w_frame_end && !r_ready;
    assign w_nibble     = r_act_val[{r_digit, 2'b00} +: 4];
    assign w_anode_on   = ~(4'b0001 << r_digit);

    // Segment and decimal-point pattern for the current slot, honouring per-digit blank.
    always_comb begin
        w_seg = 7'b1111111;
        w_dp  = 1'b1;
        if (r_act_blank[r_digit]) begin
            w_seg = 7'b1111111;
            w_dp  = 1'b1;
        end else begin
            w_seg = hex7(w_nibble);
            w_dp  = ~r_act_dp[r_digit];
        end
    end

    // Prescaler and digit-slot sequencer; free-running regardless of the handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= {CW{1'b0}};
            r_digit <= 2'd0;
        end else if (w_slot_end) begin
            r_cnt   <= {CW{1'b0}};
            r_digit <= r_digit + 2'd1;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // Blank/drive FSM with registered pin outputs switched on the same edge as the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_BLANK;
            r_anode   <= 4'b1111;
            r_cathode <= 7'b1111111;
            r_dp      <= 1'b1;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (w_blank_done) begin
                        r_state   <= ST_DRIVE;
                        r_anode   <= w_anode_on;
                        r_cathode <= w_seg;
                        r_dp      <= w_dp;
                    end else begin
                        r_anode   <= 4'b1111;
                        r_cathode <= 7'b1111111;
                        r_dp      <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (w_slot_end) begin
                        r_state   <= ST_BLANK;
                        r_anode   <= 4'b1111;
                        r_cathode <= 7'b1111111;
                        r_dp      <= 1'b1;
                    end else begin
                        r_anode   <= w_anode_on;
                        r_cathode <= w_seg;
                        r_dp      <= w_dp;
                    end
                end
                default: begin
                    r_state   <= ST_BLANK;
                    r_anode   <= 4'b1111;
                    r_cathode <= 7'b1111111;
                    r_dp      <= 1'b1;
                end
            endcase
        end
    end

    // Load staging and frame-boundary commit; a commit never sees data staged on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ready      <= 1'b1;
            r_act_val    <= 16'h0000;
            r_act_dp     <= 4'h0;
            r_act_blank  <= 4'h0;
            r_pend_val   <= 16'h0000;
            r_pend_dp    <= 4'h0;
            r_pend_blank <= 4'h0;
        end else if (w_commit) begin
            r_act_val    <= r_pend_val;
            r_act_dp     <= r_pend_dp;
            r_act_blank  <= r_pend_blank;
            r_pend_val   <= 16'h0000;
            r_pend_dp    <= 4'h0;
            r_pend_blank <= 4'h0;
            r_ready      <= 1'b1;
        end else if (w_accept) begin
            r_pend_val   <= bus.value_in;
            r_pend_dp    <= bus.dp_in;
            r_pend_blank <= bus.blank_in;
            r_ready      <= 1'b0;
        end else begin
            r_ready      <= r_ready;
        end
    end

    assign bus.ready     = r_ready;
    assign bus.digit_sel = r_digit;
    assign bus.anode     = r_anode;
    assign bus.cathode   = r_cathode;
    assign bus.dp        = r_dp;
endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Bench for seg_scan_scheduler with PRESCALE=8, BLANK_CYCLES=2 (32-clock frame).
// The reference model works from the cycle count since reset: slot = t/8 mod 4,
// blank window = first 2 clocks of a slot, and a staged value becomes visible at
// the first frame boundary strictly after the accepting edge.
module tb_seg_scan_scheduler;
    localparam int PS = 8;
    localparam int BC = 2;
    localparam int FR = 4 * PS;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clock;
    logic reset_n;
    seg_scan_scheduler_if bus();

    seg_scan_scheduler #(.PRESCALE(PS), .BLANK_CYCLES(BC)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_cmp;
    int          n_fail;
    int          t;
    int          commit_t;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    logic [15:0] p_val;
    logic [3:0]  p_dp;
    logic [3:0]  p_blank;
    bit          m_ready;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        t        = 0;
        commit_t = 0;
        m_val    = 16'h0000;
        m_dp     = 4'h0;
        m_blank  = 4'h0;
        p_val    = 16'h0000;
        p_dp     = 4'h0;
        p_blank  = 4'h0;
        m_ready  = 1'b1;
    endtask

    // One clock: check cycle t outputs at the falling edge, drive inputs, advance.
    task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        int         slot;
        int         phase;
        logic [3:0] ea;
        logic [6:0] ec;
        logic       edp;
        logic [3:0] nib;
        if (!m_ready && t == commit_t) begin
            m_val   = p_val;
            m_dp    = p_dp;
            m_blank = p_blank;
            m_ready = 1'b1;
        end
        slot  = (t / PS) % 4;
        phase = t % PS;
        ea = 4'b1111; ec = 7'b1111111; edp = 1'b1;
        if (phase >= BC) begin
            ea  = ~(4'b0001 << slot);
            nib = 4'((m_val >> (4 * slot)) & 16'h000F);
            if (!m_blank[slot]) begin
                ec  = GLYPH[nib];
                edp = ~m_dp[slot];
            end
        end
        check("anode",     {12'h000, bus.anode},     {12'h000, ea});
        check("cathode",   {9'h000, bus.cathode},    {9'h000, ec});
        check("dp",        {15'h0000, bus.dp},       {15'h0000, edp});
        check("ready",     {15'h0000, bus.ready},    {15'h0000, m_ready});
        check("digit_sel", {14'h0000, bus.digit_sel}, 16'(slot));
        bus.load     = ld;
        bus.value_in = v;
        bus.dp_in    = d;
        bus.blank_in = b;
        if (ld && m_ready) begin
            p_val    = v;
            p_dp     = d;
            p_blank  = b;
            m_ready  = 1'b0;
            commit_t = ((t + 1) / FR + 1) * FR;
        end
        @(posedge clock);
        @(negedge clock);
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 4'h0, 4'h0);
    endtask

    task automatic idle_to_phase(input int ph);
        while (t % FR != ph) step(1'b0, 16'h0000, 4'h0, 4'h0);
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        bus.load     = 1'b0;
        bus.value_in = 16'h0000;
        bus.dp_in    = 4'h0;
        bus.blank_in = 4'h0;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_anode",   {12'h000, bus.anode},   16'h000F);
        check("rst_cathode", {9'h000, bus.cathode},  16'h007F);
        check("rst_dp",      {15'h0000, bus.dp},     16'h0001);
        check("rst_ready",   {15'h0000, bus.ready},  16'h0001);
        check("rst_digit",   {14'h0000, bus.digit_sel}, 16'h0000);
        reset_n = 1'b1;

        // Idle frame: every digit shows 0.
        idle(FR);
        // Load 1A8F with dp on digit 2 at slot-relative cycle 5, then an ignored load at 10.
        idle_to_phase(5);
        step(1'b1, 16'h1A8F, 4'b0100, 4'b0000);
        idle(4);
        step(1'b1, 16'h5555, 4'b1111, 4'b1111);
        idle(2 * FR);
        // Load exactly on the frame-end edge: commits one frame later.
        idle_to_phase(FR - 1);
        step(1'b1, 16'hC3E9, 4'b0001, 4'b0000);
        idle(2 * FR + 4);
        // Blank the leftmost digit.
        idle_to_phase(3);
        step(1'b1, 16'h1234, 4'b0000, 4'b1000);
        idle(2 * FR);

        // Randomised loads.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0)
                step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
            else
                step(1'b0, 16'h0000, 4'h0, 4'h0);
        end

        // Async reset mid-drive of digit 2 with a pending value.
        idle_to_phase(2);
        if (!m_ready) idle(FR);
        step(1'b1, 16'hBEEF, 4'b1010, 4'b0000);
        idle_to_phase(2 * PS + 4);
        bus.load = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_anode",   {12'h000, bus.anode},   16'h000F);
        check("arst_cathode", {9'h000, bus.cathode},  16'h007F);
        check("arst_dp",      {15'h0000, bus.dp},     16'h0001);
        check("arst_ready",   {15'h0000, bus.ready},  16'h0001);
        check("arst_digit",   {14'h0000, bus.digit_sel}, 16'h0000);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        idle(2 * FR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
